// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit to every frame.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Total line bits per frame: start + payload + [parity] + stop.
  function automatic int frame_bits(input int data_bits);
`ifdef UART_TX_PARITY_EN
    return data_bits + 3;
`else
    return data_bits + 2;
`endif
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after 'last', wrapping.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      pick,
  output logic               valid
);

  logic [IW-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        pick  = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// ack is combinational in the IDLE arbitration cycle; the frame starts on the next cycle.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1,
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [IW-1:0]                  grant_id,
  output logic                           busy,
  output logic                           tx
);

  state_t                 state;
  logic [CW-1:0]          baud;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic [IW-1:0]          last;
  logic [IW-1:0]          pick;
  logic                   pick_vld;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   slice;
`ifdef UART_TX_PARITY_EN
  logic                   par;
`endif

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .last  (last),
    .pick  (pick),
    .valid (pick_vld)
  );

  assign bit_end = (baud == CW'(CLKS_PER_BIT - 1));
  assign slice   = data[int'(pick)*DATA_BITS +: DATA_BITS];

  always_comb begin
    ack = '0;
    if (!rst && state == IDLE && pick_vld) ack[pick] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      last     <= IW'(NUM_REQ - 1);  // requester 0 searched first after reset
      grant_id <= '0;
      busy     <= 1'b0;
      tx       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      // Counter restarts on every bit boundary and stays at 0 in IDLE, so accept restarts it too.
      baud <= (state == IDLE || bit_end) ? '0 : baud + CW'(1);
      case (state)
        IDLE: begin
          if (pick_vld) begin
            shreg    <= slice;
            grant_id <= pick;
            last     <= pick;
            busy     <= 1'b1;
            tx       <= START_BIT;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            par      <= ^slice;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= STOP_BIT;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= STOP_BIT;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            busy  <= 1'b0;
            tx    <= IDLE_LEVEL;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a cycle-level reference model predicts
// each accept and its frame; an independent monitor checks ack, grant_id, busy and tx.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FB = DB + 3;
`else
  localparam int FB = DB + 2;
`endif
  localparam int FCYC  = FB * CPB;
  localparam int LIMIT = 3000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DB-1:0] data = '0;
  logic [N-1:0]    ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic            tx;

  uart_tx_scheduler #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  typedef struct {
    int             cyc;
    int             id;
    logic [FB-1:0]  bits;
  } exp_t;
  exp_t sb[$];

  typedef logic [7:0] bq_t[$];
  bq_t          rq [N];
  logic [N-1:0] pulse = '0;
  logic [N-1:0] ack_cap = '0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Line bits in transmit order, bit 0 first: start, payload LSB first, [even parity], stop.
  function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: hold req while a byte is queued, drop the byte the cycle after its ack.
  always @(negedge clk) ack_cap = ack;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_cap[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req[i] = (rq[i].size() > 0) || pulse[i];
      data[i*DB +: DB] = (rq[i].size() > 0) ? rq[i][0] : 8'($urandom);
    end
  end

  // Reference model: line free again FCYC+1 cycles after an accept; round-robin from last winner.
  int   m_last = N - 1;
  int   m_free = 0;
  int   m_w;
  exp_t m_e;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      m_last = N - 1;
      m_free = cyc;
      sb.delete();
    end else if (cyc >= m_free && req != '0) begin
      m_w = -1;
      for (int k = 1; k <= N; k++) begin
        if (m_w < 0 && ((req >> ((m_last + k) % N)) & N'(1)) != '0) m_w = (m_last + k) % N;
      end
      m_e.cyc  = cyc;
      m_e.id   = m_w;
      m_e.bits = frame_of(8'(data >> (m_w * DB)));
      sb.push_back(m_e);
      m_last = m_w;
      m_free = cyc + FCYC + 1;
    end
  end

  // Monitor
  bit           mon_act = 1'b0;
  bit           mon_gap = 1'b0;
  bit           rst_seen = 1'b0;
  bit           due;
  int           pos, glitch, busy_bad, ack_bad;
  exp_t         cur;
  logic [FB-1:0] obs;
  logic [N-1:0] exp_ack;
  always @(negedge clk) begin
    if (rst) begin
      if (!rst_seen) begin
        chk(tx === 1'b1 && busy === 1'b0 && ack === '0 && grant_id === 2'd0, "reset_state",
            64'({tx, busy, ack, grant_id}), 64'({1'b1, 1'b0, 4'h0, 2'd0}));
        rst_seen = 1'b1;
      end
      mon_act = 1'b0;
      mon_gap = 1'b0;
    end else begin
      rst_seen = 1'b0;
      if (mon_act) begin
        if (pos % CPB == 0) obs = {tx, obs[FB-1:1]};
        else if (tx !== obs[FB-1]) glitch++;
        if (busy !== 1'b1) busy_bad++;
        if (pos == 0) chk(grant_id == 2'(cur.id), "grant_id", 64'(grant_id), 64'(cur.id));
        pos++;
        if (pos == FCYC) begin
          chk(obs === cur.bits && glitch == 0, "frame_tx", 64'(obs), 64'(cur.bits));
          chk(busy_bad == 0 && ack_bad == 0, "busy_ack_in_frame", 64'(busy_bad + ack_bad), 64'd0);
          mon_act = 1'b0;
          mon_gap = 1'b1;
        end else if (ack !== '0) ack_bad++;
      end else if (mon_gap) begin
        chk(tx === 1'b1 && busy === 1'b0, "idle_gap", 64'({tx, busy}), 64'(2'b10));
        mon_gap = 1'b0;
      end
      due = sb.size() > 0 && sb[0].cyc <= cyc;
      if ((ack !== '0 && !mon_act) || due) begin
        exp_ack = due ? (N'(1) << sb[0].id) : '0;
        chk(ack === exp_ack, "ack", 64'(ack), 64'(exp_ack));
        if (due) begin
          cur = sb.pop_front();
          if (ack === exp_ack) begin
            mon_act  = 1'b1;
            mon_gap  = 1'b0;
            pos      = 0;
            glitch   = 0;
            busy_bad = 0;
            ack_bad  = 0;
          end
        end
      end
    end
  end

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
    return sb.size() > 0 || mon_act || mon_gap;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (any_pending() && n < LIMIT) begin
      @(posedge clk);
      n++;
    end
    chk(n < LIMIT, name, 64'(n), 64'(LIMIT));
  endtask

  task automatic wait_pop(input int i);
    int n = 0;
    while (rq[i].size() > 0 && n < LIMIT) begin
      @(posedge clk);
      n++;
    end
    chk(n < LIMIT, "wait_ack", 64'(n), 64'(LIMIT));
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single byte A5 from requester 0
    @(posedge clk);
    rq[0].push_back(8'hA5);
    wait_idle("to_single");

    // All four requesting, two rounds: order 0,1,2,3,0,1,2,3
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) rq[i].push_back(8'(8'h10 + i));
    wait_idle("to_all4");

    // Short req1 pulse during a req0 frame must not produce a frame
    rq[0].push_back(8'h07);
    wait_pop(0);
    repeat (8) @(posedge clk);
    pulse[1] = 1'b1;
    repeat (2) @(posedge clk);
    pulse[1] = 1'b0;
    wait_idle("to_pulse");

    // Reset during data bit 4 of a req2 frame; afterwards priority restarts at 0
    rq[2].push_back(8'($urandom));
    wait_pop(2);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    rq[2].push_back(8'h03);
    rq[3].push_back(8'h5C);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle("to_reset");

    // Requester 1 streaming three bytes
    rq[1].push_back(8'h07);
    rq[1].push_back(8'h03);
    rq[1].push_back(8'($urandom));
    wait_idle("to_stream");

    // Random traffic
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) rq[i].push_back(8'($urandom));
      repeat ($urandom_range(0, 50)) @(posedge clk);
    end
    wait_idle("to_random");

    chk(sb.size() == 0, "scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmit line between NUM_REQ byte producers. It arbitrates round-robin between pending requests, accepts one byte per frame with a req/ack handshake, and serializes it as 8N1 (optionally 8E1) at a fixed baud derived from clk. It sits between the lab's data sources (counters, keypad/display logic) and the board TX pin, and owns all frame timing.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 2
DATA_BITS, 8, payload bits per frame, sent LSB first

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester level request; held until ack
data  input  NUM_REQ*DATA_BITS  payload; requester i uses data[i*DATA_BITS +: DATA_BITS]
ack  output  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted this cycle
grant_id  output  $clog2(NUM_REQ)  index of requester owning the current/last frame
busy  output  1  high from cycle after accept through last stop-bit cycle
tx  output  1  serial line, registered, idle high

Behaviour:
- Reset (async assert): tx=1, ack=0, busy=0, grant_id=0, state=IDLE, baud counter=0, round-robin pointer so requester 0 has top priority. Reset mid-frame aborts it; tx goes high immediately; no ack re-issued, and the byte is lost.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: if any req bit is high, pick the first set bit searching from (last grant + 1) mod NUM_REQ, wrapping. In that cycle pulse ack[winner], latch data slice into shift register, set grant_id, go to START. If req=0, stay in IDLE with tx=1.
- data is sampled only in the ack cycle. A req dropped before ack is never sent. A requester may hold req high to stream bytes; each ack consumes one byte.
- START: tx=0 for exactly CLKS_PER_BIT cycles, starting the cycle after ack.
- DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..DATA_BITS-1.
- STOP: tx=1 for CLKS_PER_BIT cycles; on its last cycle go to IDLE, with busy low from the next cycle.
- Baud counter counts 0..CLKS_PER_BIT-1, resets on every bit boundary and on accept, with no drift across bits.
- Back-to-back: the IDLE arbitration cycle adds 1 extra high cycle. Frame period = (2+DATA_BITS)*CLKS_PER_BIT + 1 cycles (8N1).
- Fairness: with all req high, grants cycle 0,1,2,3,0,...; a single active requester gets consecutive frames.
- Requests arriving while busy wait and have no effect on the current frame.

Optional Feature:
UART_TX_PARITY_EN: when defined, the PARITY state is inserted after DATA and sends the even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles, making the frame 11 bits. When undefined, the PARITY state and its logic do not exist, and the frame is 10 bits.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1, FRAME_BITS function of DATA_BITS and the parity macro.
- Sub-module uart_rr_arbiter: combinational round-robin pick from req plus last-grant pointer, with a valid flag; the scheduler owns the pointer register and updates it on accept.

Test Plan:
- CLKS_PER_BIT=4, req=0001, data0=8'hA5 -> ack[0] for 1 cycle; tx = 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles); busy high those 40 cycles; grant_id=0.
- All four req held high, data i = 8'h10+i -> frames in order 10,11,12,13,10; each ack one cycle; frames 41 cycles apart.
- req1 pulsed 2 cycles while a req0 frame is in progress, then dropped -> no ack[1], no extra frame.
- rst asserted at the 5th data bit of a frame -> tx=1 in the same cycle; after release with req2 high, frame from req2 (priority restarts at 0; req0/1 low).
- With UART_TX_PARITY_EN, data=8'h07 -> parity bit 1 after the data bits; with data=8'h03 -> parity 0; frame is 44 cycles at CLKS_PER_BIT=4.
- Single requester streaming 3 bytes (req held) -> 3 frames, each stop bit followed by exactly 1 extra idle-high cycle.
